// File: rtl/pipeline_ctrl_if.sv
// Pipeline control bundle: hazard requests and fetch outputs in, IF/ID state and stage enables out.
// With PIPE_PERF_CNT_EN defined the bundle also carries the performance counters.
interface pipeline_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  stall;
  logic                  flush;
  logic                  mem_busy;
  logic [DATA_WIDTH-1:0] instr_f;
  logic [DATA_WIDTH-1:0] pc_f;
  logic [DATA_WIDTH-1:0] pc_plus4_f;
  logic [DATA_WIDTH-1:0] instr_d;
  logic [DATA_WIDTH-1:0] pc_d;
  logic [DATA_WIDTH-1:0] pc_plus4_d;
  logic                  valid_d;
  logic                  en_pc;
  logic                  bubble_e;
  logic                  freeze_m;
  logic [1:0]            ctrl_state;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0]           cycle_cnt;
  logic [31:0]           stall_cnt;
  logic [31:0]           flush_cnt;
  logic [31:0]           wait_cnt;
`endif

  modport master (
`ifdef PIPE_PERF_CNT_EN
    input  cycle_cnt, stall_cnt, flush_cnt, wait_cnt,
`endif
    output stall, flush, mem_busy, instr_f, pc_f, pc_plus4_f,
    input  instr_d, pc_d, pc_plus4_d, valid_d, en_pc, bubble_e, freeze_m, ctrl_state
  );

  modport slave (
`ifdef PIPE_PERF_CNT_EN
    output cycle_cnt, stall_cnt, flush_cnt, wait_cnt,
`endif
    input  stall, flush, mem_busy, instr_f, pc_f, pc_plus4_f,
    output instr_d, pc_d, pc_plus4_d, valid_d, en_pc, bubble_e, freeze_m, ctrl_state
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline control: owns IF/ID, applies stall/flush/mem-wait; optional counters under PIPE_PERF_CNT_EN.
// Latency: IF/ID updates one edge after the decision; en_pc/bubble_e/freeze_m are combinational.
// Backpressure: mem_busy freezes the pipe (PC and IF/ID hold, EX/MEM and MEM/WB frozen) until it drops.
module pipeline_ctrl #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    RST_HOLD   = 2,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic           clk,
  input  logic           rst,
  pipeline_ctrl_if.slave pif
);

  typedef enum logic [1:0] {
    INIT     = 2'b00,
    RUN      = 2'b01,
    MEM_WAIT = 2'b10
  } state_t;

  localparam int            HW        = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(RST_HOLD - 1);

  state_t                state_q, state_d;
  logic [HW-1:0]         hold_q, hold_d;
  logic [DATA_WIDTH-1:0] instr_q, pc_q, pc4_q;
  logic                  valid_q;

  logic en_pc, bubble_e, freeze_m;
  logic d_load, d_nop;
  logic stall_app, flush_app;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    en_pc     = 1'b0;
    bubble_e  = 1'b1;
    freeze_m  = 1'b0;
    d_load    = 1'b0;
    d_nop     = 1'b0;
    stall_app = 1'b0;
    flush_app = 1'b0;

    case (state_q)
      // MEM_WAIT with memory ready resolves exactly like RUN in the same cycle
      RUN, MEM_WAIT: begin
        if (pif.mem_busy) begin
          bubble_e = 1'b0;
          freeze_m = 1'b1;
          state_d  = MEM_WAIT;
        end else begin
          state_d = RUN;
          if (pif.flush) begin
            en_pc     = 1'b1;
            d_nop     = 1'b1;
            flush_app = 1'b1;
          end else if (pif.stall) begin
            stall_app = 1'b1;
          end else begin
            en_pc    = 1'b1;
            bubble_e = 1'b0;
            d_load   = 1'b1;
          end
        end
      end
      // INIT, and the unreachable encoding treated as INIT with an expired counter
      default: begin
        d_nop = 1'b1;
        if (state_q == INIT && hold_q != '0) begin
          hold_d = hold_q - HW'(1);
        end else begin
          state_d = RUN;
        end
      end
    endcase

    if (rst) begin
      en_pc    = 1'b0;
      bubble_e = 1'b1;
      freeze_m = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      hold_q  <= HOLD_INIT;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      if (d_nop) begin
        instr_q <= NOP_INSTR;
        pc_q    <= '0;
        pc4_q   <= '0;
        valid_q <= 1'b0;
      end else if (d_load) begin
        instr_q <= pif.instr_f;
        pc_q    <= pif.pc_f;
        pc4_q   <= pif.pc_plus4_f;
        valid_q <= 1'b1;
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] cycle_q, stall_q, flush_q, wait_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
      wait_q  <= '0;
    end else begin
      if (state_q == RUN || state_q == MEM_WAIT) cycle_q <= cycle_q + 32'd1;
      if (stall_app) stall_q <= stall_q + 32'd1;
      if (flush_app) flush_q <= flush_q + 32'd1;
      if (freeze_m)  wait_q  <= wait_q + 32'd1;
    end
  end

  assign pif.cycle_cnt = cycle_q;
  assign pif.stall_cnt = stall_q;
  assign pif.flush_cnt = flush_q;
  assign pif.wait_cnt  = wait_q;
`endif

  assign pif.instr_d    = instr_q;
  assign pif.pc_d       = pc_q;
  assign pif.pc_plus4_d = pc4_q;
  assign pif.valid_d    = valid_q;
  assign pif.en_pc      = en_pc;
  assign pif.bubble_e   = bubble_e;
  assign pif.freeze_m   = freeze_m;
  assign pif.ctrl_state = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: per-cycle expectations queued by the driver, popped by a monitor.
module tb_pipeline_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_ctrl_if #(.DATA_WIDTH(32)) pif ();

  pipeline_ctrl #(
    .DATA_WIDTH(32),
    .RST_HOLD  (2),
    .NOP_INSTR (NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pif(pif)
  );

  // ctl = {en_pc, bubble_e, freeze_m, ctrl_state}
  typedef struct {
    logic [4:0]  ctl;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        vld;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, req);
    end
  endtask

  // in = {rst, stall, flush, mem_busy}
  task automatic step(input logic [3:0] in, input logic [31:0] i, input logic [31:0] p,
                      input logic [31:0] p4, input logic [4:0] e_ctl, input logic [31:0] e_i,
                      input logic [31:0] e_p, input logic [31:0] e_p4, input logic e_v);
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    rst            = in[3];
    pif.stall      = in[2];
    pif.flush      = in[1];
    pif.mem_busy   = in[0];
    pif.instr_f    = i;
    pif.pc_f       = p;
    pif.pc_plus4_f = p4;
    e.ctl   = e_ctl;
    e.instr = e_i;
    e.pc    = e_p;
    e.pc4   = e_p4;
    e.vld   = e_v;
    e.cyc   = cyc;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("en_pc",      e.cyc, 32'(pif.en_pc),      32'(e.ctl[4]));
        check("bubble_e",   e.cyc, 32'(pif.bubble_e),   32'(e.ctl[3]));
        check("freeze_m",   e.cyc, 32'(pif.freeze_m),   32'(e.ctl[2]));
        check("ctrl_state", e.cyc, 32'(pif.ctrl_state), 32'(e.ctl[1:0]));
        check("instr_d",    e.cyc, pif.instr_d,         e.instr);
        check("pc_d",       e.cyc, pif.pc_d,            e.pc);
        check("pc_plus4_d", e.cyc, pif.pc_plus4_d,      e.pc4);
        check("valid_d",    e.cyc, 32'(pif.valid_d),    32'(e.vld));
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : driver
    pif.stall      = 1'b0;
    pif.flush      = 1'b0;
    pif.mem_busy   = 1'b0;
    pif.instr_f    = '0;
    pif.pc_f       = '0;
    pif.pc_plus4_f = '0;

    // reset, then two INIT cycles with all requests ignored
    step(4'b1000, 32'h0, 32'h0, 32'h0, 5'b01000, NOP, 32'h0, 32'h0, 1'b0);
    step(4'b0111, 32'h0, 32'h0, 32'h0, 5'b01000, NOP, 32'h0, 32'h0, 1'b0);
    step(4'b0000, 32'h00A00093, 32'h40, 32'h44, 5'b01000, NOP, 32'h0, 32'h0, 1'b0);
    // first RUN cycle: PC enabled, D still invalid until the edge
    step(4'b0000, 32'h00A00093, 32'h40, 32'h44, 5'b10001, NOP, 32'h0, 32'h0, 1'b0);
    // two consecutive stalls hold D
    step(4'b0100, 32'h00B00113, 32'h44, 32'h48, 5'b01001, 32'h00A00093, 32'h40, 32'h44, 1'b1);
    step(4'b0100, 32'h00B00113, 32'h44, 32'h48, 5'b01001, 32'h00A00093, 32'h40, 32'h44, 1'b1);
    step(4'b0000, 32'h00B00113, 32'h44, 32'h48, 5'b10001, 32'h00A00093, 32'h40, 32'h44, 1'b1);
    // stall + flush: flush wins
    step(4'b0110, 32'h00C00193, 32'h48, 32'h4C, 5'b11001, 32'h00B00113, 32'h44, 32'h48, 1'b1);
    step(4'b0000, 32'h00D00213, 32'h4C, 32'h50, 5'b10001, NOP, 32'h0, 32'h0, 1'b0);
    // three mem-busy cycles with flush asserted: frozen, flush ignored
    step(4'b0011, 32'h00E00293, 32'h50, 32'h54, 5'b00101, 32'h00D00213, 32'h4C, 32'h50, 1'b1);
    step(4'b0011, 32'h00E00293, 32'h50, 32'h54, 5'b00110, 32'h00D00213, 32'h4C, 32'h50, 1'b1);
    step(4'b0011, 32'h00E00293, 32'h50, 32'h54, 5'b00110, 32'h00D00213, 32'h4C, 32'h50, 1'b1);
    // memory ready: resolves as RUN while state still reads MEM_WAIT
    step(4'b0000, 32'h00E00293, 32'h50, 32'h54, 5'b10010, 32'h00D00213, 32'h4C, 32'h50, 1'b1);
    step(4'b0000, 32'h00F00313, 32'h54, 32'h58, 5'b10001, 32'h00E00293, 32'h50, 32'h54, 1'b1);
    // busy, then stall resolved on the wait-exit cycle
    step(4'b0001, 32'h01000393, 32'h58, 32'h5C, 5'b00101, 32'h00F00313, 32'h54, 32'h58, 1'b1);
    step(4'b0100, 32'h01000393, 32'h58, 32'h5C, 5'b01010, 32'h00F00313, 32'h54, 32'h58, 1'b1);
    step(4'b0001, 32'h01000393, 32'h58, 32'h5C, 5'b00101, 32'h00F00313, 32'h54, 32'h58, 1'b1);
    // reset during MEM_WAIT
    step(4'b1001, 32'h01000393, 32'h58, 32'h5C, 5'b01010, 32'h00F00313, 32'h54, 32'h58, 1'b1);
    step(4'b0111, 32'h01000393, 32'h58, 32'h5C, 5'b01000, NOP, 32'h0, 32'h0, 1'b0);
    step(4'b0111, 32'h01000393, 32'h58, 32'h5C, 5'b01000, NOP, 32'h0, 32'h0, 1'b0);
    // flush alone, then normal fetch and PC wrap copy
    step(4'b0010, 32'h01000393, 32'h58, 32'h5C, 5'b11001, NOP, 32'h0, 32'h0, 1'b0);
    step(4'b0000, 32'h01000393, 32'h58, 32'h5C, 5'b10001, NOP, 32'h0, 32'h0, 1'b0);
    step(4'b0000, 32'h12345678, 32'hFFFFFFFC, 32'h0, 5'b10001, 32'h01000393, 32'h58, 32'h5C, 1'b1);
    step(4'b0000, 32'h0, 32'h0, 32'h4, 5'b10001, 32'h12345678, 32'hFFFFFFFC, 32'h0, 1'b1);

    repeat (2) @(posedge clk);
    check("queue_drained", cyc, 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
